// File: rtl/spi_arb_pkg.sv
// Shared encodings and widths for the SPI transfer arbiter.
package spi_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int DATA_W_DEF = 32;
  localparam int TMO_W      = 16;

endpackage

// File: rtl/spi_xfer_arbiter_cmpl_sync.sv
// Brings the engine completion flag into clk and turns its falling edge
// into a single-cycle registered pulse.
module spi_cmpl_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse_out
);

  logic s1_q, s2_q, s3_q;
  logic pulse_q, pulse_d;

  // falling edge of the synchronized level (s3 is the delayed copy)
  always_comb pulse_d = s3_q & ~s2_q;

  // two-flop synchronizer, delay flop and registered edge pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= async_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one SPI word engine between NUM_REQ requesters.
//
//   state  | meaning
//   IDLE   | no grant; pick next requester round-robin
//   LAUNCH | grant held, start pulse issued next cycle, timer cleared
//   WAIT   | waiting for engine completion or timeout
//   DONE   | done/timeout_err pulse to the winner, grant released next
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_rd,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      timeout_err,
  output logic                      busy,
  output logic                      spi_go,
  output logic [DATA_W-1:0]         spi_wdata,
  input  logic                      data_pack_ready,
  input  logic [DATA_W-1:0]         data_read_from_spi
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                terr_q, terr_d;
  logic                go_q, go_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    win;
  logic                cmpl;
  logic                tmo_hit;

  // first set request after p, wrapping around
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] w;
    logic             found;
    int               idx;
    w     = p;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (!found && r[idx]) begin
        w     = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  spi_cmpl_sync u_cmpl_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (data_pack_ready),
    .pulse_out (cmpl)
  );

  assign win     = rr_pick(req, ptr_q);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // next-state and output decisions
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    terr_d  = 1'b0;
    go_d    = 1'b0;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    if (!enable) begin
      state_d = IDLE;
      gnt_d   = '0;
      rdata_d = '0;
      wdata_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_d = '0;
          if (|req) begin
            gnt_d[win] = 1'b1;
            ptr_d      = win;
            wdata_d    = req_rd[win] ? '0 : req_wdata[int'(win)*DATA_W +: DATA_W];
            state_d    = LAUNCH;
          end
        end
        LAUNCH: begin
          go_d    = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (cmpl) begin
            rdata_d = data_read_from_spi;
            done_d  = gnt_q;
            state_d = DONE;
          end else if (tmo_hit) begin
            rdata_d = '0;
            done_d  = gnt_q;
            terr_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      terr_q  <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign spi_go      = go_q;
  assign busy        = busy_q;
  assign rdata       = rdata_q;
  assign spi_wdata   = wdata_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed plus randomized bench for spi_xfer_arbiter with a round-robin
// reference model and an SPI engine model driving the completion flag.
module tb_spi_xfer_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  req_rd = '0;
  logic          ready = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic [N-1:0]  gnt, done;
  logic [DW-1:0] rdata, spi_wdata;
  logic          terr, busy, spi_go;

  logic [N-1:0]  req_t = '0;
  logic          ready_t = 1'b1;
  logic [DW-1:0] rd_data_t = '0;
  logic [N-1:0]  gnt_t, done_t;
  logic [DW-1:0] rdata_t, spi_wdata_t;
  logic          terr_t, busy_t, spi_go_t;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] wd [N];
  logic [N-1:0]  pending = '0;
  int            last_w = N - 1;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req),
    .req_wdata(req_wdata), .req_rd(req_rd), .gnt(gnt), .done(done),
    .rdata(rdata), .timeout_err(terr), .busy(busy), .spi_go(spi_go),
    .spi_wdata(spi_wdata), .data_pack_ready(ready),
    .data_read_from_spi(rd_data)
  );

  spi_xfer_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req_t),
    .req_wdata(req_wdata), .req_rd(req_rd), .gnt(gnt_t), .done(done_t),
    .rdata(rdata_t), .timeout_err(terr_t), .busy(busy_t), .spi_go(spi_go_t),
    .spi_wdata(spi_wdata_t), .data_pack_ready(ready_t),
    .data_read_from_spi(rd_data_t)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_wd(input int i, input logic [DW-1:0] v);
    wd[i] = v;
    req_wdata[i*DW +: DW] = v;
  endtask

  // reference round-robin: first pending requester after the last winner
  function automatic int model_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++)
      if (p[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // one complete transfer on the main DUT, engine answers after lat cycles
  task automatic xfer(input int lat, input logic [DW-1:0] rd, input bit drop);
    int w, n;
    logic [DW-1:0] ew;
    w  = model_pick(pending, last_w);
    ew = req_rd[w] ? '0 : wd[w];
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 50);
    chk("gnt_latency", n, 1);
    chk("gnt_winner", gnt, 1 << w);
    @(negedge clk);
    chk("spi_go", spi_go, 1);
    chk("spi_wdata", spi_wdata, ew);
    chk("busy", busy, 1);
    repeat (lat) begin
      @(negedge clk);
      chk("go_one_cycle", spi_go, 0);
      chk("no_early_done", done, 0);
    end
    ready   = 1'b0;
    rd_data = rd;
    n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 100);
    chk("done_latency", n, 4);
    chk("done_vec", done, 1 << w);
    chk("rdata", rdata, rd);
    chk("terr_clear", terr, 0);
    chk("gnt_in_done", gnt, 1 << w);
    last_w = w;
    if (drop) begin
      pending[w] = 1'b0;
      req = pending;
    end
    ready = 1'b1;
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("gnt_released", gnt, 0);
    chk("rdata_held", rdata, rd);
  endtask

  initial begin
    int n;
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) set_wd(i, $urandom);
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wdata", spi_wdata, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // single write
    set_wd(0, 32'hA5A5_0001);
    pending = 4'b0001; req = pending;
    xfer(20, $urandom, 1);

    // read command sends an all-zero word
    req_rd[2] = 1'b1;
    pending = 4'b0100; req = pending;
    xfer(5, 32'hDEAD_BEEF, 1);
    req_rd = '0;

    // fairness with all requests held
    pending = 4'b1111; req = pending;
    for (int i = 0; i < 8; i++) xfer($urandom_range(2, 8), $urandom, 0);
    pending = '0; req = pending;
    @(negedge clk);

    // randomized request patterns
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < N; i++) set_wd(i, $urandom);
      req_rd  = N'($urandom_range(0, 15));
      pending = pending | N'($urandom_range(0, 15));
      if (pending == '0) pending = N'(1 << $urandom_range(0, N - 1));
      req = pending;
      xfer($urandom_range(2, 20), $urandom, 1);
    end
    req_rd = '0;
    while (pending != '0) xfer($urandom_range(2, 6), $urandom, 1);

    // timeout on the short-timeout instance, then a normal transfer
    req_t = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt_t == '0 && n < 50);
    chk("t_gnt", gnt_t, 4'b0001);
    @(negedge clk);
    chk("t_go", spi_go_t, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (done_t == '0 && n < 100);
    chk("t_latency", n, 16);
    chk("t_done", done_t, 4'b0001);
    chk("t_err", terr_t, 1);
    chk("t_rdata", rdata_t, 0);
    req_t = '0;
    @(negedge clk);
    chk("t_err_pulse", terr_t, 0);
    req_t = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt_t == '0 && n < 50);
    chk("t2_gnt", gnt_t, 4'b0010);
    repeat (3) @(negedge clk);
    r = $urandom;
    ready_t = 1'b0; rd_data_t = r;
    n = 0;
    do begin @(negedge clk); n++; end while (done_t == '0 && n < 100);
    chk("t2_done", done_t, 4'b0010);
    chk("t2_err", terr_t, 0);
    chk("t2_rdata", rdata_t, r);
    req_t = '0; ready_t = 1'b1;
    repeat (4) @(negedge clk);

    // abort during WAIT on requester 1
    pending = 4'b0010; req = pending;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 50);
    chk("ab_gnt", gnt, 4'b0010);
    repeat (4) @(negedge clk);
    pending = 4'b0110; req = pending;
    enable = 1'b0;
    @(negedge clk);
    chk("ab_gnt_clr", gnt, 0);
    chk("ab_busy", busy, 0);
    chk("ab_wdata", spi_wdata, 0);
    chk("ab_rdata", rdata, 0);
    ready = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done != '0 || gnt != '0) n++;
    end
    chk("ab_quiet", n, 0);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    last_w = 1;
    xfer(4, $urandom, 1);
    xfer(4, $urandom, 1);

    // reset in the middle of WAIT
    pending = 4'b1000; req = pending;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 50);
    chk("rs_gnt", gnt, 4'b1000);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_gnt0", gnt, 0);
    chk("rs_busy0", busy, 0);
    chk("rs_wdata0", spi_wdata, 0);
    chk("rs_rdata0", rdata, 0);
    chk("rs_done0", done, 0);
    repeat (3) @(negedge clk);
    chk("rs_hold", gnt | done, 0);
    pending = 4'b0011; req = pending;
    reset_n = 1'b1;
    last_w = N - 1;
    xfer(3, $urandom, 1);
    xfer(3, $urandom, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
